// File: rtl/rv_muldiv.sv
// RV-M multiply/divide unit: iterative shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign correction on
// completion. Divide-by-zero and signed overflow skip the iteration phase.
module rv_muldiv #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_sel_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_reg, state_next;
  logic [2:0]          op_reg;
  logic                sign1_reg, sign2_reg;
  logic [XLEN-1:0]     opnd_reg;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_reg;       // product, or {remainder, dividend/quotient}
  logic [XLEN-1:0]     result_reg;
  logic [CNT_W-1:0]    cnt_reg;

  // Request decode: signedness, magnitudes and the two bypass cases
  logic            accept, is_div, signed1, signed2, sign1_in, sign2_in;
  logic            div_zero, div_ovf, bypass;
  logic [XLEN-1:0] mag1, mag2, bypass_result;

  assign accept   = (state_reg == IDLE) && valid_i && !kill_i;
  assign is_div   = op_sel_i[2];
  assign signed1  = (op_sel_i == 3'b000) || (op_sel_i == 3'b001) || (op_sel_i == 3'b010) ||
                    (op_sel_i == 3'b100) || (op_sel_i == 3'b110);
  assign signed2  = (op_sel_i == 3'b000) || (op_sel_i == 3'b001) ||
                    (op_sel_i == 3'b100) || (op_sel_i == 3'b110);
  assign sign1_in = signed1 && op1_i[XLEN-1];
  assign sign2_in = signed2 && op2_i[XLEN-1];
  assign mag1     = sign1_in ? -op1_i : op1_i;
  assign mag2     = sign2_in ? -op2_i : op2_i;
  assign div_zero = is_div && (op2_i == '0);
  // Only DIV (100) and REM (110) are signed divides, both have bit 0 clear
  assign div_ovf  = is_div && !op_sel_i[0] && (op1_i == MOST_NEG) && (op2_i == '1);
  assign bypass   = div_zero || div_ovf;
  assign bypass_result = div_zero ? (op_sel_i[1] ? op1_i : '1)
                                  : (op_sel_i[1] ? '0    : op1_i);

  // One iteration step of each algorithm
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
  assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  // Partial remainder stays below 2*divisor, so the top bit is a clean borrow
  assign div_ok    = !div_diff[XLEN];
  assign div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                      acc_reg[XLEN-2:0], div_ok};

  // Sign correction and result selection at the end of the iteration phase
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  assign prod_fix = (sign1_reg ^ sign2_reg) ? -acc_reg : acc_reg;
  assign quo_fix  = (sign1_reg ^ sign2_reg) ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
  assign rem_fix  = sign1_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
  assign final_result = op_reg[2] ? (op_reg[1] ? rem_fix : quo_fix)
                                  : ((op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                            : prod_fix[2*XLEN-1:XLEN]);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; kill always wins over progress or handshake
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = bypass ? DONE : CALC;
      CALC: begin
        if (kill_i)              state_next = IDLE;
        else if (cnt_reg == '0)  state_next = DONE;
      end
      DONE: if (kill_i || ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, finalize when the count is spent
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_reg     <= '0;
      sign1_reg  <= 1'b0;
      sign2_reg  <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else if (accept) begin
      op_reg    <= op_sel_i;
      sign1_reg <= sign1_in;
      sign2_reg <= sign2_in;
      opnd_reg  <= is_div ? mag2 : mag1;
      acc_reg   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
      cnt_reg   <= bypass ? '0 : CNT_W'(XLEN);
      if (bypass) result_reg <= bypass_result;
    end else if (state_reg == CALC && !kill_i) begin
      if (cnt_reg != '0) begin
        acc_reg <= op_reg[2] ? div_next : mul_next;
        cnt_reg <= cnt_reg - CNT_W'(1);
      end else begin
        result_reg <= final_result;
      end
    end
  end

  assign ready_o  = (state_reg == IDLE);
  assign valid_o  = (state_reg == DONE);
  assign result_o = result_reg;
  assign zero_o   = (result_reg == '0);

endmodule
